vga_plot_arbiter: RTL and testbench

Owns the single VGA adapter write port (plot/x/y/colour) and shares it between the snake body renderer and the food spawner, replacing the combinational food-over-snake override. It also contains a screen-clear sequencer. The sequencer sweeps the full 160x120 frame after reset and on request, for example on game over or restart. It sits between the datapath pixel producers and `vga_adapter`, whose `plot` input it drives directly.

---
 rtl/vga_plot_arbiter.sv | 133 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Single owner of the VGA adapter write port: clears the frame after reset or on request, then round-robins snake/food pixels.
// Optional build macro PLOT_ARB_BORDER_EN paints the frame perimeter in BORDER_COLOUR during the clear sweep.
module vga_plot_arbiter #(
   parameter int         WIDTH         = 160,
   parameter int         HEIGHT        = 120,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [2:0] BORDER_COLOUR = 3'b001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_req,
   input  logic       snake_req,
   input  logic [7:0] snake_x,
   input  logic [6:0] snake_y,
   input  logic [2:0] snake_colour,
   output logic       snake_ack,
   input  logic       food_req,
   input  logic [7:0] food_x,
   input  logic [6:0] food_y,
   input  logic [2:0] food_colour,
   output logic       food_ack,
   output logic       plot,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       busy,
   output logic       clear_done
);

   localparam logic       ST_CLEAR = 1'b0;
   localparam logic       ST_ARB   = 1'b1;
   localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
   localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);

`ifdef PLOT_ARB_BORDER_EN
   localparam logic BORDER_ON = 1'b1;
`else
   localparam logic BORDER_ON = 1'b0;
`endif

   logic       state;
   logic [7:0] cx;
   logic [6:0] cy;
   logic       last_food;
   logic [7:0] sx;
   logic [6:0] sy;
   logic       on_edge;
   logic [2:0] sweep_colour;
   logic       snake_live;
   logic       food_live;
   logic       grant_snake;
   logic       grant_food;

   // A restart request takes effect on the pixel being written this cycle.
   // A request whose ack is showing this cycle has already been served.
   always_comb begin
      sx           = clear_req ? 8'd0 : cx;
      sy           = clear_req ? 7'd0 : cy;
      on_edge      = (sx == 8'd0) || (sx == X_LAST) || (sy == 7'd0) || (sy == Y_LAST);
      sweep_colour = (BORDER_ON && on_edge) ? BORDER_COLOUR : BG_COLOUR;
      snake_live   = snake_req && !snake_ack;
      food_live    = food_req && !food_ack;
      grant_snake  = snake_live && (!food_live || last_food);
      grant_food   = food_live && !grant_snake;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_CLEAR;
         cx         <= 8'd0;
         cy         <= 7'd0;
         last_food  <= 1'b1;
         plot       <= 1'b0;
         x          <= 8'd0;
         y          <= 7'd0;
         colour     <= 3'd0;
         snake_ack  <= 1'b0;
         food_ack   <= 1'b0;
         busy       <= 1'b1;
         clear_done <= 1'b0;
      end else begin
         snake_ack  <= 1'b0;
         food_ack   <= 1'b0;
         clear_done <= 1'b0;
         plot       <= 1'b0;
         if (state == ST_CLEAR) begin
            plot   <= 1'b1;
            x      <= sx;
            y      <= sy;
            colour <= sweep_colour;
            if (sx == X_LAST && sy == Y_LAST) begin
               state      <= ST_ARB;
               cx         <= 8'd0;
               cy         <= 7'd0;
               busy       <= 1'b0;
               clear_done <= 1'b1;
            end else if (sx == X_LAST) begin
               cx   <= 8'd0;
               cy   <= sy + 7'd1;
               busy <= 1'b1;
            end else begin
               cx   <= sx + 8'd1;
               cy   <= sy;
               busy <= 1'b1;
            end
         end else if (clear_req) begin
            // Clear outranks any pending pixel; the requester keeps holding.
            state <= ST_CLEAR;
            cx    <= 8'd0;
            cy    <= 7'd0;
            busy  <= 1'b1;
         end else begin
            busy <= 1'b0;
            if (grant_snake) begin
               snake_ack <= 1'b1;
               last_food <= 1'b0;
               x         <= snake_x;
               y         <= snake_y;
               colour    <= snake_colour;
               plot      <= (snake_x <= X_LAST) && (snake_y <= Y_LAST);
            end else if (grant_food) begin
               food_ack  <= 1'b1;
               last_food <= 1'b1;
               x         <= food_x;
               y         <= food_y;
               colour    <= food_colour;
               plot      <= (food_x <= X_LAST) && (food_y <= Y_LAST);
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: a pixel-index model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_vga_plot_arbiter;

   localparam int W = 160;
   localparam int H = 120;
`ifdef PLOT_ARB_BORDER_EN
   localparam logic [2:0] EDGE_C = 3'b001;
`else
   localparam logic [2:0] EDGE_C = 3'b000;
`endif

   logic       clk = 1'b0;
   logic       reset, clear_req;
   logic       snake_req, food_req;
   logic [7:0] snake_x, food_x;
   logic [6:0] snake_y, food_y;
   logic [2:0] snake_colour, food_colour;
   logic       snake_ack, food_ack, plot, busy, clear_done;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   int total = 0;
   int bad = 0;
   int printed = 0;

   vga_plot_arbiter dut (
      .clk(clk), .reset(reset), .clear_req(clear_req),
      .snake_req(snake_req), .snake_x(snake_x), .snake_y(snake_y), .snake_colour(snake_colour),
      .snake_ack(snake_ack),
      .food_req(food_req), .food_x(food_x), .food_y(food_y), .food_colour(food_colour),
      .food_ack(food_ack),
      .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy), .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   // Model state: clear progress is a linear pixel index, arbitration a "who went last" flag.
   logic       model_valid = 1'b0;
   logic       m_clearing;
   int         m_p;
   logic       m_last_food;
   logic       e_plot, e_sack, e_fack, e_busy, e_done;
   logic [7:0] e_x;
   logic [6:0] e_y;
   logic [2:0] e_colour;

   function automatic logic [2:0] sweep_colour(int px, int py);
      if (px == 0 || px == W - 1 || py == 0 || py == H - 1) return EDGE_C;
      return 3'b000;
   endfunction

   always @(posedge clk) begin
      logic s_live, f_live;
      int   who;
      model_valid = 1'b1;
      if (reset) begin
         m_clearing = 1'b1; m_p = 0; m_last_food = 1'b1;
         e_plot = 0; e_x = 0; e_y = 0; e_colour = 0;
         e_sack = 0; e_fack = 0; e_busy = 1; e_done = 0;
      end else if (m_clearing) begin
         if (clear_req) m_p = 0;
         e_sack = 0; e_fack = 0;
         e_plot = 1;
         e_x = 8'(m_p % W);
         e_y = 7'(m_p / W);
         e_colour = sweep_colour(m_p % W, m_p / W);
         if (m_p == W * H - 1) begin
            e_done = 1; e_busy = 0; m_clearing = 0; m_p = 0;
         end else begin
            e_done = 0; e_busy = 1; m_p = m_p + 1;
         end
      end else begin
         s_live = snake_req && !e_sack;
         f_live = food_req && !e_fack;
         e_sack = 0; e_fack = 0; e_done = 0; e_plot = 0;
         if (clear_req) begin
            m_clearing = 1; m_p = 0; e_busy = 1;
         end else begin
            e_busy = 0;
            who = 0;
            if (s_live && f_live) who = m_last_food ? 1 : 2;
            else if (s_live) who = 1;
            else if (f_live) who = 2;
            if (who == 1) begin
               e_sack = 1; m_last_food = 0;
               e_x = snake_x; e_y = snake_y; e_colour = snake_colour;
               e_plot = (int'(snake_x) < W) && (int'(snake_y) < H);
            end else if (who == 2) begin
               e_fack = 1; m_last_food = 1;
               e_x = food_x; e_y = food_y; e_colour = food_colour;
               e_plot = (int'(food_x) < W) && (int'(food_y) < H);
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [22:0] act, want;
      if (model_valid) begin
         act  = {plot, x, y, colour, snake_ack, food_ack, busy, clear_done};
         want = {e_plot, e_x, e_y, e_colour, e_sack, e_fack, e_busy, e_done};
         total++;
         if (act !== want) begin
            bad++;
            if (printed < 20) begin
               printed++;
               $display("[TB] FAIL cycle_model t=%0t got=%h want=%h", $time, act, want);
            end
         end
      end
   end

   task automatic check_output(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   task automatic apply_stimulus(logic clr, logic sr, logic [7:0] sxv, logic [6:0] syv, logic [2:0] sc,
                                 logic fr, logic [7:0] fxv, logic [6:0] fyv, logic [2:0] fc);
      clear_req = clr;
      snake_req = sr; snake_x = sxv; snake_y = syv; snake_colour = sc;
      food_req  = fr; food_x  = fxv; food_y  = fyv; food_colour  = fc;
   endtask

   function automatic logic [7:0] rand_x();
      if ($urandom_range(0, 7) == 0) return 8'($urandom_range(160, 255));
      return 8'($urandom_range(0, 159));
   endfunction

   function automatic logic [6:0] rand_y();
      if ($urandom_range(0, 7) == 0) return 7'($urandom_range(120, 127));
      return 7'($urandom_range(0, 119));
   endfunction

   // Requesters only change their request when idle or just acknowledged.
   task automatic random_drive();
      if (!snake_req || snake_ack) begin
         snake_req = ($urandom_range(0, 2) != 0);
         snake_x = rand_x(); snake_y = rand_y(); snake_colour = 3'($urandom_range(0, 7));
      end
      if (!food_req || food_ack) begin
         food_req = ($urandom_range(0, 2) != 0);
         food_x = rand_x(); food_y = rand_y(); food_colour = 3'($urandom_range(0, 7));
      end
   endtask

   initial begin
      int plot_cnt, done_cnt, early_ack, restart_k, done_k;
      reset = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      check_output("reset_values", 32'({plot, x, y, colour, snake_ack, food_ack, busy, clear_done}), 32'h2);
      reset = 1'b0;
      clear_req = 1'b0;

      plot_cnt = 0; done_cnt = 0;
      for (int k = 1; k <= 19205; k++) begin
         @(negedge clk);
         if (plot) plot_cnt++;
         if (clear_done) done_cnt++;
         if (k == 1)     check_output("first_pixel", {plot, x, y, colour}, {1'b1, 8'd0, 7'd0, EDGE_C});
         if (k == 2)     check_output("second_pixel", {x, y}, {8'd1, 7'd0});
         if (k == 161)   check_output("row1_start", {x, y}, {8'd0, 7'd1});
         if (k == 9601)  check_output("pix_0_60", {x, y, colour}, {8'd0, 7'd60, EDGE_C});
         if (k == 9681)  check_output("pix_80_60", {x, y, colour}, {8'd80, 7'd60, 3'd0});
         if (k == 19200) check_output("last_pixel", {x, y, clear_done, busy}, {8'd159, 7'd119, 1'b1, 1'b0});
         if (k == 19201) check_output("after_clear", {plot, busy}, 2'b00);
      end
      check_output("plot_count", plot_cnt, 19200);
      check_output("done_count", done_cnt, 1);

      apply_stimulus(0, 1, 8'd10, 7'd20, 3'd7, 0, 0, 0, 0);
      @(negedge clk);
      check_output("snake_grant", {snake_ack, plot, x, y, colour}, {1'b1, 1'b1, 8'd10, 7'd20, 3'd7});
      snake_req = 1'b0;
      @(negedge clk);
      check_output("no_double_plot", {snake_ack, plot}, 2'b00);
      @(negedge clk);
      check_output("still_idle", plot, 0);

      apply_stimulus(0, 1, 8'd5, 7'd5, 3'd7, 1, 8'd30, 7'd40, 3'd4);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check_output("alternate", {snake_ack, food_ack}, (k % 2 == 1) ? 2'b01 : 2'b10);
      end
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      apply_stimulus(0, 0, 0, 0, 0, 1, 8'd200, 7'd5, 3'd4);
      @(negedge clk);
      check_output("oor_ack", {food_ack, plot, x}, {1'b1, 1'b0, 8'd200});
      food_req = 1'b0;
      @(negedge clk);
      check_output("oor_single", {food_ack, plot}, 2'b00);

      apply_stimulus(1, 1, 8'd7, 7'd8, 3'd2, 0, 0, 0, 0);
      @(negedge clk);
      clear_req = 1'b0;
      check_output("clear_wins", {snake_ack, plot, busy}, 3'b001);
      early_ack = 0; restart_k = 0; done_k = 0;
      for (int k = 1; k <= 30000; k++) begin
         @(negedge clk);
         clear_req = 1'b0;
         if (snake_ack) early_ack++;
         if (k == 5000) clear_req = 1'b1;
         if (k == 5001) begin
            restart_k = k;
            check_output("restart_origin", {plot, x, y}, {1'b1, 8'd0, 7'd0});
         end
         if (clear_done) begin
            done_k = k;
            break;
         end
      end
      clear_req = 1'b0;
      check_output("sweep_length", done_k - restart_k, 19199);
      check_output("no_ack_in_clear", early_ack, 0);
      @(negedge clk);
      check_output("ack_after_clear", {snake_ack, x, y, colour}, {1'b1, 8'd7, 7'd8, 3'd2});
      snake_req = 1'b0;

      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         random_drive();
      end
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         random_drive();
      end
      reset = 1'b0;
      for (int k = 0; k < 19200 + 1500; k++) begin
         @(negedge clk);
         random_drive();
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
